hack_core_mc: RTL
=================

# hack_core_mc

Parametrised multicycle Hack CPU core. It fetches 16-bit Hack instructions and accesses data memory over independent req/ack handshakes, so instruction and data memories may insert any number of wait states. The ALU, A/D registers and PC are widened to DATA_W. A front-end FSM sequences fetch, optional data read, execute and optional data write. This block is the next-generation replacement for the single-cycle datapath and sits between the SoC memory fabric and the debug/halt logic.

## Interface
- DATA_W, 16: register, ALU, PC and address width; must be ≥16 (elaboration-time assertion).
- PC_STEP, 2: PC increment per sequential instruction (byte-addressed program memory).

- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  instruction fetch request; held until imem_ack_i
- imem_addr_o  out  DATA_W  fetch address (= PC)
- imem_ack_i  in  1  fetch complete; imem_rdata_i valid this cycle
- imem_rdata_i  in  16  instruction word
- dmem_req_o  out  1  data access request; held until dmem_ack_i
- dmem_we_o  out  1  1 = write, 0 = read
- dmem_addr_o  out  DATA_W  data address (= A)
- dmem_wdata_o  out  DATA_W  write data (ALU result)
- dmem_ack_i  in  1  data access complete; read data valid this cycle
- dmem_rdata_i  in  DATA_W  read data
- halt_i  in  1  stop after the current instruction retires
- retire_o  out  1  one-cycle pulse when an instruction commits
- halted_o  out  1  core in HALT state
- pc_o, regA_o, regD_o  out  DATA_W  architectural state

## Operation
- Decode: bit15=0 is an A-instruction; A ← zero-extend(instr[14:0]).
- Decode: bit15=1 is a C-instruction: bit12 a (ALU y = M if 1, else A); bits11:6 zx,nx,zy,ny,f,no; bits5:3 dest A,D,M; bits2:0 j1(<0),j2(=0),j3(>0).
- ALU: x = D, y = A or MDR. zx/zy zero the operand, then nx/ny invert it. f=1 gives x+y (mod 2^DATA_W); f=0 gives x&y. no inverts the result.
- Flags: zr = (out==0); ng = out[DATA_W-1].
- Jump = (j1&ng)|(j2&zr)|(j3&~ng&~zr).
- Next PC = jump ? A_old : PC+PC_STEP, wrapping mod 2^DATA_W.
- FSM states:
  - FETCH: imem_req_o=1. On ack, IR ← rdata. Go to MEM_RD if C with a=1, else EXEC.
  - MEM_RD: dmem_req_o=1, we=0, addr=A. On ack, MDR ← rdata, go to EXEC.
  - EXEC: latch the ALU result into RES. If dest M, go to MEM_WR. Otherwise commit.
  - MEM_WR: dmem_req_o=1, we=1, addr=A_old, wdata=RES. On ack, commit.
  - HALT: no requests. Go to FETCH the cycle after halt_i=0.
- Commit (single cycle): A, D and PC update together, retire_o=1. Dest A, jump target and the M address all use A_old. Next state is HALT if halt_i=1, else FETCH.
- Request outputs are registered-stable: once a req is asserted, addr/we/wdata do not change until ack. halt_i does not abort an outstanding request.
- A C-instruction with dest=000 and no jump still retires (NOP). AM=M+1 is legal: read, then write the same address.

## Timing
- Reset values: PC=A=D=IR=MDR=RES=0; state FETCH; all req outputs 0 during reset. imem_req_o rises in the first cycle after resetb deasserts. retire_o=0, halted_o=0.
- Ack may arrive in the same cycle the req rises (zero wait states).
- Minimum cycles per instruction: A-instr or plain C = 2; C read or C write = 3; read+write = 4. Each wait cycle on an ack adds one cycle.
- halt_i is sampled only in the commit cycle; halted_o rises the next cycle.
- An ack arriving while the corresponding req=0 is ignored.
- Reset mid-access drops the req immediately; the memory side must discard the transaction.

## Structure
- Package hack_pkg holds:
  - state enum {FETCH, MEM_RD, EXEC, MEM_WR, HALT}
  - instruction bit-position localparams
  - function jump_taken(j, zr, ng)
- Sub-module hack_alu #(DATA_W) holds the combinational ALU with zr/ng.
- The FSM, registers and handshakes live in hack_core_mc.

## Test plan
- Zero-wait memories, program "@5; D=A; @7; D=D+A; @2; M=D":
  - retire_o pulses 6 times.
  - D=12 (0x000C).
  - dmem write addr 2, wdata 12.
  - 13 cycles total.
- Random 0–5 cycle ack delays on both ports, same program: identical final state. req/addr/wdata stay stable while waiting.
- "@100; D=A; @10; D;JGT": PC becomes 10 after the jump.
- "@0; D;JEQ" with D=0 loops at PC=2. With D=5, PC advances to 4.
- DATA_W=32: "@32767; D=A; D=D+1; D=D+A" gives D=0x0000FFFF, no wrap. "@0; D=!A; D=D+1" gives D=0 and zr jump taken.
- halt_i asserted mid-fetch: the instruction completes, halted_o=1, no requests. Deassert halt_i: fetch resumes at the next PC. Then pulse resetb during a MEM_RD wait: req drops, PC=0 restart.

Source files
------------

// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the multicycle Hack core.
//   state_t       front-end FSM states
//   I_*           instruction bit positions
//   jump_taken()  Hack jump condition from j1..j3 and the ALU flags
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        MEM_RD = 3'd1,
        EXEC   = 3'd2,
        MEM_WR = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam int I_CTYPE = 15;  // 1 = C-instruction
    localparam int I_IMM_W = 15;  // A-instruction immediate width
    localparam int I_ABIT  = 12;  // ALU y operand: 1 = M, 0 = A
    localparam int I_CMP_H = 11;  // zx,nx,zy,ny,f,no
    localparam int I_CMP_L = 6;
    localparam int I_DST_A = 5;
    localparam int I_DST_D = 4;
    localparam int I_DST_M = 3;
    localparam int I_JMP_H = 2;   // j1(<0), j2(=0), j3(>0)
    localparam int I_JMP_L = 0;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU, DATA_W wide.
//   x, y  operands (x = D, y = A or M)
//   ctl   {zx, nx, zy, ny, f, no}
//   res   result; zr = (res == 0); ng = res sign bit
module hack_alu #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        ctl,
    output logic [DATA_W-1:0] res,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] xz, xn, yz, yn, fo;

    always_comb begin
        xz  = ctl[5] ? '0 : x;
        xn  = ctl[4] ? ~xz : xz;
        yz  = ctl[3] ? '0 : y;
        yn  = ctl[2] ? ~yz : yz;
        fo  = ctl[1] ? (xn + yn) : (xn & yn);
        res = ctl[0] ? ~fo : fo;
        zr  = (res == '0);
        ng  = res[DATA_W-1];
    end

endmodule

// File: rtl/hack_core_mc.sv
// hack_core_mc: multicycle Hack CPU core with req/ack instruction and data ports.
//   clk, resetb                      clock, async active-low reset
//   imem_req_o/addr_o/ack_i/rdata_i  instruction fetch handshake (addr = PC)
//   dmem_req_o/we_o/addr_o/wdata_o   data access handshake (addr = A, wdata = RES)
//   dmem_ack_i/rdata_i               data access completion / read data
//   halt_i                           stop after the current instruction retires
//   retire_o                         one-cycle commit pulse
//   halted_o                         core parked in HALT
//   pc_o, regA_o, regD_o             architectural state
module hack_core_mc
    import hack_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PC_STEP = 2
) (
    input  logic              clk,
    input  logic              resetb,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [15:0]       imem_rdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              halt_i,
    output logic              retire_o,
    output logic              halted_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] regA_o,
    output logic [DATA_W-1:0] regD_o
);

    if (DATA_W < 16) begin : g_bad_width
        $error("hack_core_mc: DATA_W must be >= 16");
    end

    state_t            state;
    logic [DATA_W-1:0] pc, a, d, mdr, res;
    logic [15:0]       ir;
    logic              imem_req, dmem_req;

    logic [DATA_W-1:0] alu_out;
    logic              zr, ng;
    logic              is_c, dest_a, dest_d, dest_m, jump, commit;
    logic              imem_fire, dmem_fire;

    // ALU operands come only from registers that change at commit, so the
    // result stays valid through MEM_WR and can be reused at commit time.
    hack_alu #(.DATA_W(DATA_W)) u_alu (
        .x   (d),
        .y   (ir[I_ABIT] ? mdr : a),
        .ctl (ir[I_CMP_H:I_CMP_L]),
        .res (alu_out),
        .zr  (zr),
        .ng  (ng)
    );

    assign is_c   = ir[I_CTYPE];
    assign dest_a = is_c & ir[I_DST_A];
    assign dest_d = is_c & ir[I_DST_D];
    assign dest_m = is_c & ir[I_DST_M];
    assign jump   = is_c & jump_taken(ir[I_JMP_H:I_JMP_L], zr, ng);

    // Acks are only honoured while the matching request is up.
    assign imem_fire = imem_req & imem_ack_i;
    assign dmem_fire = dmem_req & dmem_ack_i;

    assign commit = ((state == EXEC) & ~dest_m) | ((state == MEM_WR) & dmem_fire);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= FETCH;
            pc       <= '0;
            a        <= '0;
            d        <= '0;
            ir       <= '0;
            mdr      <= '0;
            res      <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        // first cycle out of reset
                        imem_req <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir       <= imem_rdata_i;
                        imem_req <= 1'b0;
                        if (imem_rdata_i[I_CTYPE] && imem_rdata_i[I_ABIT]) begin
                            state    <= MEM_RD;
                            dmem_req <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                MEM_RD: begin
                    if (dmem_fire) begin
                        mdr      <= dmem_rdata_i;
                        dmem_req <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res <= alu_out;
                    if (dest_m) begin
                        state    <= MEM_WR;
                        dmem_req <= 1'b1;
                    end
                end
                MEM_WR: begin
                    if (dmem_fire) dmem_req <= 1'b0;
                end
                HALT: begin
                    if (!halt_i) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: state <= FETCH;
            endcase

            if (commit) begin
                // A, D, PC update together; jump target uses A before this write.
                if (!is_c)       a <= {{(DATA_W-I_IMM_W){1'b0}}, ir[I_IMM_W-1:0]};
                else if (dest_a) a <= alu_out;
                if (dest_d)      d <= alu_out;
                pc <= jump ? a : pc + DATA_W'(PC_STEP);
                if (halt_i) begin
                    state <= HALT;
                end else begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            end
        end
    end

    assign imem_req_o   = imem_req;
    assign imem_addr_o  = pc;
    assign dmem_req_o   = dmem_req;
    assign dmem_we_o    = (state == MEM_WR);
    assign dmem_addr_o  = a;
    assign dmem_wdata_o = res;
    assign retire_o     = commit;
    assign halted_o     = (state == HALT);
    assign pc_o         = pc;
    assign regA_o       = a;
    assign regD_o       = d;

endmodule
